// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard and forwarding unit beside decode: shadow scoreboard of in-flight writes
// (EX..WB), per-operand forwarding select, load-use stall insertion and a stall counter.
module pipe_hazard_fwd_unit #(
  parameter int XLEN       = 16,
  parameter int NREG       = 8,
  parameter int DEPTH      = 3,
  parameter int NSRC       = 2,
  parameter int LOAD_STAGE = 2,
  parameter int ZERO_HARD  = 0,
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NSRC*AW-1:0]     id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [AW-1:0]          id_dest,
  input  logic                   id_wr_en,
  input  logic                   id_is_load,
  input  logic                   flush,
  input  logic [DEPTH*XLEN-1:0]  stage_data,
  input  logic [NSRC*XLEN-1:0]   rf_data,
  input  logic                   stat_clr,
  output logic [NSRC*XLEN-1:0]   opnd,
  output logic [NSRC*SW-1:0]     fwd_sel,
  output logic                   stall,
  output logic                   issue,
  output logic [SW-1:0]          inflight,
  output logic [15:0]            stall_cnt
);

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [DEPTH:1]  ent_v;
  logic [DEPTH:1]  ent_we;
  logic [DEPTH:1]  ent_ld;
  logic [AW-1:0]   ent_dest [1:DEPTH];
  logic [NSRC-1:0] not_ready;
  logic [AW-1:0]   src_s;

  // Match stage: scanning oldest to youngest lets the smallest k overwrite older hits.
  always_comb begin
    opnd      = rf_data;
    fwd_sel   = '0;
    not_ready = '0;
    src_s     = '0;
    for (int s = 0; s < NSRC; s++) begin
      src_s = id_src[s*AW +: AW];
      for (int k = DEPTH; k >= 1; k--) begin
        if (ent_v[k] && ent_we[k] && id_src_used[s] && (ent_dest[k] == src_s) &&
            !((ZERO_HARD != 0) && (src_s == '0))) begin
          fwd_sel[s*SW +: SW]  = SW'(k);
          opnd[s*XLEN +: XLEN] = stage_data[(k-1)*XLEN +: XLEN];
          not_ready[s]         = ent_ld[k] && (k < LOAD_STAGE);
        end
      end
    end
  end

  assign stall = id_valid && !flush && (|not_ready);
  assign issue = id_valid && !flush && !(|not_ready);

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      inflight = inflight + SW'(ent_v[k] & ent_we[k]);
    end
  end

  // Scoreboard control: valid bits shift every cycle, a bubble enters on stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_v <= '0;
    end else begin
      ent_v[1] <= issue;
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k] <= ent_v[k-1];
      end
    end
  end

  // Scoreboard payload is only meaningful under ent_v, so it carries no reset.
  always_ff @(posedge clk) begin
    ent_dest[1] <= id_dest;
    ent_we[1]   <= id_wr_en;
    ent_ld[1]   <= id_is_load;
    for (int k = DEPTH; k >= 2; k--) begin
      ent_dest[k] <= ent_dest[k-1];
      ent_we[k]   <= ent_we[k-1];
      ent_ld[k]   <= ent_ld[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Bench for pipe_hazard_fwd_unit: default build checked against an age-based issue-history
// model, plus a DEPTH=5/NSRC=3/ZERO_HARD build and a long-load build for counter saturation.
module tb_pipe_hazard_fwd_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  // Instance A: defaults
  logic        a_id_valid, a_id_wr_en, a_id_is_load, a_flush, a_stat_clr;
  logic [5:0]  a_id_src;
  logic [1:0]  a_src_used;
  logic [2:0]  a_id_dest;
  logic [47:0] a_stage_data;
  logic [31:0] a_rf_data, a_opnd;
  logic [3:0]  a_fwd_sel;
  logic        a_stall, a_issue;
  logic [1:0]  a_inflight;
  logic [15:0] a_stall_cnt;

  // Instance B: DEPTH=5, NSRC=3, ZERO_HARD=1, LOAD_STAGE=4
  logic        b_id_valid, b_id_wr_en, b_id_is_load, b_flush, b_stat_clr;
  logic [8:0]  b_id_src;
  logic [2:0]  b_src_used;
  logic [2:0]  b_id_dest;
  logic [79:0] b_stage_data;
  logic [47:0] b_rf_data, b_opnd;
  logic [8:0]  b_fwd_sel;
  logic        b_stall, b_issue;
  logic [2:0]  b_inflight;
  logic [15:0] b_stall_cnt;

  // Instance C: DEPTH=16, LOAD_STAGE=16 gives 15 stalls per 16 cycles
  logic         c_id_valid, c_id_wr_en, c_id_is_load, c_flush, c_stat_clr;
  logic [2:0]   c_id_src;
  logic [0:0]   c_src_used;
  logic [2:0]   c_id_dest;
  logic [127:0] c_stage_data;
  logic [7:0]   c_rf_data, c_opnd;
  logic [4:0]   c_fwd_sel;
  logic         c_stall, c_issue;
  logic [4:0]   c_inflight;
  logic [15:0]  c_stall_cnt;

  pipe_hazard_fwd_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(a_id_valid), .id_src(a_id_src),
    .id_src_used(a_src_used), .id_dest(a_id_dest), .id_wr_en(a_id_wr_en),
    .id_is_load(a_id_is_load), .flush(a_flush), .stage_data(a_stage_data),
    .rf_data(a_rf_data), .stat_clr(a_stat_clr), .opnd(a_opnd), .fwd_sel(a_fwd_sel),
    .stall(a_stall), .issue(a_issue), .inflight(a_inflight), .stall_cnt(a_stall_cnt)
  );

  pipe_hazard_fwd_unit #(.XLEN(16), .NREG(8), .DEPTH(5), .NSRC(3), .LOAD_STAGE(4), .ZERO_HARD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(b_id_valid), .id_src(b_id_src),
    .id_src_used(b_src_used), .id_dest(b_id_dest), .id_wr_en(b_id_wr_en),
    .id_is_load(b_id_is_load), .flush(b_flush), .stage_data(b_stage_data),
    .rf_data(b_rf_data), .stat_clr(b_stat_clr), .opnd(b_opnd), .fwd_sel(b_fwd_sel),
    .stall(b_stall), .issue(b_issue), .inflight(b_inflight), .stall_cnt(b_stall_cnt)
  );

  pipe_hazard_fwd_unit #(.XLEN(8), .NREG(8), .DEPTH(16), .NSRC(1), .LOAD_STAGE(16), .ZERO_HARD(0)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(c_id_valid), .id_src(c_id_src),
    .id_src_used(c_src_used), .id_dest(c_id_dest), .id_wr_en(c_id_wr_en),
    .id_is_load(c_id_is_load), .flush(c_flush), .stage_data(c_stage_data),
    .rf_data(c_rf_data), .stat_clr(c_stat_clr), .opnd(c_opnd), .fwd_sel(c_fwd_sel),
    .stall(c_stall), .issue(c_issue), .inflight(c_inflight), .stall_cnt(c_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout required=finish");
    $fatal(1);
  end

  // Reference model for A: history of issued instructions; an instruction issued in
  // cycle c sits at stage (now - c) while that age is 1..3.
  typedef struct {int cyc; int dest; bit we; bit ld;} rec_t;
  rec_t        qa[$];
  int          ca;
  int          mcnt_a;
  logic [3:0]  ea_sel;
  logic [31:0] ea_opnd;
  logic        ea_stall, ea_issue;
  int          ea_inflight;

  function automatic void model_a();
    bit nr = 1'b0;
    ea_sel      = '0;
    ea_opnd     = a_rf_data;
    ea_inflight = 0;
    for (int s = 0; s < 2; s++) begin
      int src = int'(a_id_src[s*3 +: 3]);
      bit found = 1'b0;
      for (int age = 1; age <= 3; age++) begin
        foreach (qa[i]) begin
          if (!found && a_src_used[s] && qa[i].cyc == ca - age && qa[i].we && qa[i].dest == src) begin
            found = 1'b1;
            ea_sel[s*2 +: 2]    = 2'(age);
            ea_opnd[s*16 +: 16] = a_stage_data[(age-1)*16 +: 16];
            if (qa[i].ld && age < 2) nr = 1'b1;
          end
        end
      end
    end
    ea_stall = a_id_valid && !a_flush && nr;
    ea_issue = a_id_valid && !a_flush && !nr;
    foreach (qa[i]) begin
      if (ca - qa[i].cyc >= 1 && ca - qa[i].cyc <= 3 && qa[i].we) ea_inflight++;
    end
  endfunction

  task automatic tick_a();
    rec_t r;
    model_a();
    @(posedge clk);
    if (ea_issue) begin
      r.cyc = ca; r.dest = int'(a_id_dest); r.we = a_id_wr_en; r.ld = a_id_is_load;
      qa.push_back(r);
    end
    if (a_stat_clr) mcnt_a = 0;
    else if (ea_stall && mcnt_a < 65535) mcnt_a++;
    ca++;
    while (qa.size() > 0 && ca - qa[0].cyc > 3) void'(qa.pop_front());
    #1;
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input bit v, input int s0, input int s1, input bit [1:0] u,
                       input int d, input bit we, input bit ld, input bit fl);
    a_id_valid   = v;
    a_id_src     = {3'(s1), 3'(s0)};
    a_src_used   = u;
    a_id_dest    = 3'(d);
    a_id_wr_en   = we;
    a_id_is_load = ld;
    a_flush      = fl;
    a_stage_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    a_rf_data    = {16'($urandom), 16'($urandom)};
  endtask

  task automatic set_b(input bit v, input logic [8:0] src, input bit [2:0] u,
                       input int d, input bit we, input bit ld);
    b_id_valid   = v;
    b_id_src     = src;
    b_src_used   = u;
    b_id_dest    = 3'(d);
    b_id_wr_en   = we;
    b_id_is_load = ld;
    b_flush      = 1'b0;
    b_stage_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    b_rf_data    = {16'($urandom), 16'($urandom), 16'($urandom)};
  endtask

  task automatic drain_a(input int n);
    for (int i = 0; i < n; i++) begin
      set_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
      tick_a();
    end
  endtask

  task automatic test_reset();
    set_a(0, 0, 0, 2'b00, 0, 0, 0, 0);
    a_stat_clr = 0;
    set_b(0, 9'd0, 3'b000, 0, 0, 0);
    b_stat_clr = 0;
    c_id_valid = 0; c_id_src = '0; c_src_used = '0; c_id_dest = '0; c_id_wr_en = 0;
    c_id_is_load = 0; c_flush = 0; c_stat_clr = 0; c_stage_data = '0; c_rf_data = 8'h5A;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_chk++; if (a_stall !== 1'b0) $display("FAIL reset_stall got=%0h exp=0", a_stall); else n_pass++;
    n_chk++; if (a_inflight !== 2'd0) $display("FAIL reset_inflight got=%0d exp=0", a_inflight); else n_pass++;
    n_chk++; if (a_stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0h exp=0", a_stall_cnt); else n_pass++;
    n_chk++; if (a_fwd_sel !== 4'd0) $display("FAIL reset_fwd_sel got=%0h exp=0", a_fwd_sel); else n_pass++;
    n_chk++; if (a_opnd !== a_rf_data) $display("FAIL reset_opnd got=%0h exp=%0h", a_opnd, a_rf_data); else n_pass++;
    n_chk++; if (b_stall_cnt !== 16'd0) $display("FAIL reset_b_stall_cnt got=%0h exp=0", b_stall_cnt); else n_pass++;
    n_chk++; if (c_stall_cnt !== 16'd0) $display("FAIL reset_c_stall_cnt got=%0h exp=0", c_stall_cnt); else n_pass++;
    qa.delete(); ca = 0; mcnt_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_chain();
    set_a(1, 0, 0, 2'b00, 3, 1, 0, 0);
    #2;
    n_chk++; if (a_issue !== 1'b1) $display("FAIL alu_issue got=%0h exp=1", a_issue); else n_pass++;
    tick_a();
    set_a(1, 3, 0, 2'b01, 4, 1, 0, 0);
    #2;
    n_chk++; if (a_fwd_sel[1:0] !== 2'd1) $display("FAIL alu_sel1 got=%0d exp=1", a_fwd_sel[1:0]); else n_pass++;
    n_chk++; if (a_opnd[15:0] !== a_stage_data[15:0]) $display("FAIL alu_opnd1 got=%0h exp=%0h", a_opnd[15:0], a_stage_data[15:0]); else n_pass++;
    n_chk++; if (a_stall !== 1'b0) $display("FAIL alu_stall got=%0h exp=0", a_stall); else n_pass++;
    tick_a();
    set_a(1, 0, 3, 2'b10, 7, 0, 0, 0);
    #2;
    n_chk++; if (a_fwd_sel[3:2] !== 2'd2) $display("FAIL alu_sel2 got=%0d exp=2", a_fwd_sel[3:2]); else n_pass++;
    n_chk++; if (a_opnd[31:16] !== a_stage_data[31:16]) $display("FAIL alu_opnd2 got=%0h exp=%0h", a_opnd[31:16], a_stage_data[31:16]); else n_pass++;
    n_chk++; if (a_opnd[15:0] !== a_rf_data[15:0]) $display("FAIL alu_unused_rf got=%0h exp=%0h", a_opnd[15:0], a_rf_data[15:0]); else n_pass++;
    tick_a();
    drain_a(3);
  endtask

  task automatic test_load_use();
    set_a(1, 0, 0, 2'b00, 2, 1, 1, 0);
    tick_a();
    set_a(1, 2, 5, 2'b11, 6, 1, 0, 0);
    #2;
    n_chk++; if (a_stall !== 1'b1) $display("FAIL lu_stall got=%0h exp=1", a_stall); else n_pass++;
    n_chk++; if (a_issue !== 1'b0) $display("FAIL lu_issue0 got=%0h exp=0", a_issue); else n_pass++;
    n_chk++; if (a_fwd_sel !== 4'b0001) $display("FAIL lu_sel_stall got=%0h exp=1", a_fwd_sel); else n_pass++;
    n_chk++; if (a_stall_cnt !== 16'd0) $display("FAIL lu_cnt0 got=%0d exp=0", a_stall_cnt); else n_pass++;
    tick_a();
    #2;
    n_chk++; if (a_stall !== 1'b0) $display("FAIL lu_stall_end got=%0h exp=0", a_stall); else n_pass++;
    n_chk++; if (a_issue !== 1'b1) $display("FAIL lu_issue1 got=%0h exp=1", a_issue); else n_pass++;
    n_chk++; if (a_fwd_sel[1:0] !== 2'd2) $display("FAIL lu_sel2 got=%0d exp=2", a_fwd_sel[1:0]); else n_pass++;
    n_chk++; if (a_opnd[15:0] !== a_stage_data[31:16]) $display("FAIL lu_opnd got=%0h exp=%0h", a_opnd[15:0], a_stage_data[31:16]); else n_pass++;
    n_chk++; if (a_stall_cnt !== 16'd1) $display("FAIL lu_cnt1 got=%0d exp=1", a_stall_cnt); else n_pass++;
    tick_a();
    drain_a(3);
  endtask

  task automatic test_youngest();
    for (int i = 0; i < 3; i++) begin
      set_a(1, 0, 0, 2'b00, 5, 1, 0, 0);
      tick_a();
    end
    set_a(1, 1, 5, 2'b10, 0, 0, 0, 0);
    #2;
    n_chk++; if (a_fwd_sel[3:2] !== 2'd1) $display("FAIL young_sel got=%0d exp=1", a_fwd_sel[3:2]); else n_pass++;
    n_chk++; if (a_opnd[31:16] !== a_stage_data[15:0]) $display("FAIL young_opnd got=%0h exp=%0h", a_opnd[31:16], a_stage_data[15:0]); else n_pass++;
    n_chk++; if (a_inflight !== 2'd3) $display("FAIL young_inflight got=%0d exp=3", a_inflight); else n_pass++;
    tick_a();
    drain_a(3);
  endtask

  task automatic test_flush();
    set_a(1, 0, 0, 2'b00, 6, 1, 1, 0);
    tick_a();
    set_a(1, 6, 0, 2'b01, 1, 1, 0, 1);
    #2;
    n_chk++; if (a_stall !== 1'b0) $display("FAIL flush_stall got=%0h exp=0", a_stall); else n_pass++;
    n_chk++; if (a_issue !== 1'b0) $display("FAIL flush_issue got=%0h exp=0", a_issue); else n_pass++;
    n_chk++; if (a_inflight !== 2'd1) $display("FAIL flush_inflight0 got=%0d exp=1", a_inflight); else n_pass++;
    tick_a();
    set_a(1, 6, 0, 2'b01, 1, 1, 0, 0);
    #2;
    n_chk++; if (a_inflight !== 2'd1) $display("FAIL flush_inflight1 got=%0d exp=1", a_inflight); else n_pass++;
    n_chk++; if (a_fwd_sel[1:0] !== 2'd2) $display("FAIL flush_bubble_sel got=%0d exp=2", a_fwd_sel[1:0]); else n_pass++;
    n_chk++; if (a_stall_cnt !== 16'(mcnt_a)) $display("FAIL flush_cnt got=%0d exp=%0d", a_stall_cnt, mcnt_a); else n_pass++;
    tick_a();
    drain_a(3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom),
            $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      a_stat_clr = ($urandom_range(0, 31) == 0);
      #2;
      model_a();
      n_chk++; if (a_fwd_sel !== ea_sel) $display("FAIL rnd_sel cyc=%0d got=%0h exp=%0h", i, a_fwd_sel, ea_sel); else n_pass++;
      n_chk++; if (a_opnd !== ea_opnd) $display("FAIL rnd_opnd cyc=%0d got=%0h exp=%0h", i, a_opnd, ea_opnd); else n_pass++;
      n_chk++; if (a_stall !== ea_stall) $display("FAIL rnd_stall cyc=%0d got=%0h exp=%0h", i, a_stall, ea_stall); else n_pass++;
      n_chk++; if (a_issue !== ea_issue) $display("FAIL rnd_issue cyc=%0d got=%0h exp=%0h", i, a_issue, ea_issue); else n_pass++;
      n_chk++; if (a_inflight !== 2'(ea_inflight)) $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", i, a_inflight, ea_inflight); else n_pass++;
      n_chk++; if (a_stall_cnt !== 16'(mcnt_a)) $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, a_stall_cnt, mcnt_a); else n_pass++;
      tick_a();
    end
    a_stat_clr = 0;
    drain_a(3);
  endtask

  task automatic test_reset_mid_stall();
    set_a(1, 0, 0, 2'b00, 1, 1, 1, 0);
    tick_a();
    set_a(1, 1, 0, 2'b01, 2, 1, 0, 0);
    #2;
    n_chk++; if (a_stall !== 1'b1) $display("FAIL rms_pre_stall got=%0h exp=1", a_stall); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if (a_stall !== 1'b0) $display("FAIL rms_stall got=%0h exp=0", a_stall); else n_pass++;
    n_chk++; if (a_stall_cnt !== 16'd0) $display("FAIL rms_cnt got=%0d exp=0", a_stall_cnt); else n_pass++;
    n_chk++; if (a_opnd !== a_rf_data) $display("FAIL rms_opnd got=%0h exp=%0h", a_opnd, a_rf_data); else n_pass++;
    n_chk++; if (a_fwd_sel !== 4'd0) $display("FAIL rms_sel got=%0h exp=0", a_fwd_sel); else n_pass++;
    n_chk++; if (a_inflight !== 2'd0) $display("FAIL rms_inflight got=%0d exp=0", a_inflight); else n_pass++;
    qa.delete(); mcnt_a = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++; if (a_issue !== 1'b1) $display("FAIL rms_issue got=%0h exp=1", a_issue); else n_pass++;
    tick_a();
    #1;
    n_chk++; if (a_inflight !== 2'd1) $display("FAIL rms_resume_inflight got=%0d exp=1", a_inflight); else n_pass++;
    drain_a(3);
  endtask

  task automatic test_zero_hard();
    set_b(1, 9'd0, 3'b000, 0, 1, 1);
    tick_b();
    set_b(1, 9'd0, 3'b111, 2, 0, 0);
    #2;
    n_chk++; if (b_fwd_sel !== 9'd0) $display("FAIL zero_sel got=%0h exp=0", b_fwd_sel); else n_pass++;
    n_chk++; if (b_stall !== 1'b0) $display("FAIL zero_stall got=%0h exp=0", b_stall); else n_pass++;
    n_chk++; if (b_opnd !== b_rf_data) $display("FAIL zero_opnd got=%0h exp=%0h", b_opnd, b_rf_data); else n_pass++;
    n_chk++; if (b_inflight !== 3'd1) $display("FAIL zero_inflight got=%0d exp=1", b_inflight); else n_pass++;
    tick_b();
    set_b(0, 9'd0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick_b();
  endtask

  task automatic test_load_stall_b();
    set_b(1, 9'd0, 3'b000, 4, 1, 1);
    tick_b();
    set_b(1, {3'd4, 3'd2, 3'd1}, 3'b100, 7, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      #2;
      n_chk++; if (b_stall !== 1'b1) $display("FAIL b_ld_stall%0d got=%0h exp=1", i, b_stall); else n_pass++;
      n_chk++; if (b_fwd_sel[8:6] !== 3'(i)) $display("FAIL b_ld_sel%0d got=%0d exp=%0d", i, b_fwd_sel[8:6], i); else n_pass++;
      n_chk++; if (b_stall_cnt !== 16'(i - 1)) $display("FAIL b_ld_cnt%0d got=%0d exp=%0d", i, b_stall_cnt, i - 1); else n_pass++;
      tick_b();
    end
    #2;
    n_chk++; if (b_issue !== 1'b1) $display("FAIL b_ld_issue got=%0h exp=1", b_issue); else n_pass++;
    n_chk++; if (b_fwd_sel !== {3'd4, 3'd0, 3'd0}) $display("FAIL b_ld_sel4 got=%0h exp=%0h", b_fwd_sel, {3'd4, 3'd0, 3'd0}); else n_pass++;
    n_chk++; if (b_opnd[47:32] !== b_stage_data[63:48]) $display("FAIL b_ld_opnd got=%0h exp=%0h", b_opnd[47:32], b_stage_data[63:48]); else n_pass++;
    n_chk++; if (b_stall_cnt !== 16'd3) $display("FAIL b_ld_cnt3 got=%0d exp=3", b_stall_cnt); else n_pass++;
    tick_b();
    set_b(0, 9'd0, 3'b000, 0, 0, 0);
  endtask

  task automatic test_saturation();
    // Self-dependent load: issue, then 15 stall cycles, repeating every 16 cycles.
    c_id_valid = 1; c_id_src = 3'd1; c_src_used = 1'b1; c_id_dest = 3'd1;
    c_id_wr_en = 1; c_id_is_load = 1; c_stat_clr = 0;
    for (int i = 0; i < 69920; i++) begin
      @(posedge clk);
      if (i == 1599) begin
        #1;
        n_chk++; if (c_stall_cnt !== 16'd1500) $display("FAIL sat_mid_cnt got=%0d exp=1500", c_stall_cnt); else n_pass++;
        n_chk++; if (c_issue !== 1'b1) $display("FAIL sat_mid_issue got=%0h exp=1", c_issue); else n_pass++;
        n_chk++; if (c_fwd_sel !== 5'd16) $display("FAIL sat_mid_sel got=%0d exp=16", c_fwd_sel); else n_pass++;
      end
    end
    #1;
    n_chk++; if (c_stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%0h exp=ffff", c_stall_cnt); else n_pass++;
    tick_b();
    n_chk++; if (c_stall !== 1'b1) $display("FAIL sat_stall_pre_clr got=%0h exp=1", c_stall); else n_pass++;
    n_chk++; if (c_stall_cnt !== 16'hFFFF) $display("FAIL sat_hold2 got=%0h exp=ffff", c_stall_cnt); else n_pass++;
    c_stat_clr = 1;
    tick_b();
    n_chk++; if (c_stall_cnt !== 16'd0) $display("FAIL sat_clr got=%0d exp=0", c_stall_cnt); else n_pass++;
    c_stat_clr = 0;
    c_id_valid = 0;
    tick_b();
    n_chk++; if (c_stall_cnt !== 16'd0) $display("FAIL sat_clr_hold got=%0d exp=0", c_stall_cnt); else n_pass++;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_flush();
    test_random();
    test_reset_mid_stall();
    test_zero_hard();
    test_load_stall_b();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
